// File: rtl/directory_controller.sv
// MSI home-node directory: serialises cache misses and writebacks, drives memory
// and snoop handshakes, and returns one response per request.
module directory_controller #(
  parameter int unsigned NUM_PROC   = 3,
  parameter int unsigned ADDR_W     = 4,
  parameter int unsigned DATA_W     = 4,
  parameter int unsigned NUM_BLOCKS = 8
) (
  input  logic                Clock,
  input  logic                Reset,
  input  logic                ReqValid,
  input  logic [1:0]          ReqType,
  input  logic [1:0]          ReqProc,
  input  logic [ADDR_W-1:0]   ReqAddress,
  input  logic [DATA_W-1:0]   ReqData,
  output logic                ReqReady,
  output logic                MemRead,
  output logic                MemWrite,
  output logic [ADDR_W-1:0]   MemAddress,
  output logic [DATA_W-1:0]   MemWriteData,
  input  logic [DATA_W-1:0]   MemReadData,
  input  logic                MemAck,
  output logic [NUM_PROC-1:0] SnoopInvalidate,
  output logic                SnoopFetch,
  output logic [1:0]          SnoopOwner,
  input  logic [DATA_W-1:0]   SnoopData,
  input  logic                SnoopAck,
  output logic                RespValid,
  output logic [1:0]          RespProc,
  output logic [ADDR_W-1:0]   RespAddress,
  output logic [DATA_W-1:0]   RespData,
  output logic                RespError
);

  localparam int unsigned IDX_W = (NUM_BLOCKS > 1) ? $clog2(NUM_BLOCKS) : 1;

  typedef enum logic [2:0] {IDLE, LOOKUP, INVAL, FETCH, MEM_WR, MEM_RD, RESP} state_e;
  typedef enum logic [1:0] {DIR_I, DIR_S, DIR_M} dir_e;

  localparam logic [1:0] REQ_RD = 2'b00;
  localparam logic [1:0] REQ_WR = 2'b01;
  localparam logic [1:0] REQ_WB = 2'b10;

  state_e               state_q, state_d;
  logic [1:0]           req_type_q, req_type_d, req_proc_q, req_proc_d;
  logic [ADDR_W-1:0]    req_addr_q, req_addr_d;
  logic [DATA_W-1:0]    req_data_q, req_data_d, data_q, data_d;
  logic                 err_q, err_d;
  logic [NUM_PROC-1:0]  snoop_mask_q, snoop_mask_d;
  logic [1:0]           owner_q, owner_d;
  dir_e                 dir_state_q [NUM_BLOCKS];
  dir_e                 dir_state_d [NUM_BLOCKS];
  logic [NUM_PROC-1:0]  dir_mask_q  [NUM_BLOCKS];
  logic [NUM_PROC-1:0]  dir_mask_d  [NUM_BLOCKS];

  logic                 req_ready_q, req_ready_d, mem_read_q, mem_read_d, mem_write_q, mem_write_d;
  logic [ADDR_W-1:0]    mem_addr_q, mem_addr_d, resp_addr_q, resp_addr_d;
  logic [DATA_W-1:0]    mem_wdata_q, mem_wdata_d, resp_data_q, resp_data_d;
  logic [NUM_PROC-1:0]  snoop_inv_q, snoop_inv_d;
  logic                 snoop_fetch_q, snoop_fetch_d, resp_valid_q, resp_valid_d, resp_error_q, resp_error_d;
  logic [1:0]           snoop_owner_q, snoop_owner_d, resp_proc_q, resp_proc_d;

  logic                 in_range, proc_ok, is_owner, bad;
  logic [IDX_W-1:0]     idx;
  dir_e                 ent_state;
  logic [NUM_PROC-1:0]  ent_mask, req_bit, others;
  logic [1:0]           ent_owner;

  always_comb begin
    state_d      = state_q;
    req_type_d   = req_type_q;
    req_proc_d   = req_proc_q;
    req_addr_d   = req_addr_q;
    req_data_d   = req_data_q;
    data_d       = data_q;
    err_d        = err_q;
    snoop_mask_d = snoop_mask_q;
    owner_d      = owner_q;
    dir_state_d  = dir_state_q;
    dir_mask_d   = dir_mask_q;

    // Entry decode for the registered request
    in_range  = (req_addr_q != '0) && (32'(req_addr_q) <= NUM_BLOCKS);
    proc_ok   = 32'(req_proc_q) < NUM_PROC;
    idx       = in_range ? IDX_W'(req_addr_q - ADDR_W'(1)) : '0;
    ent_state = dir_state_q[idx];
    ent_mask  = dir_mask_q[idx];
    req_bit   = NUM_PROC'(1) << req_proc_q;
    others    = ent_mask & ~req_bit;
    ent_owner = '0;
    for (int unsigned i = 0; i < NUM_PROC; i++) begin
      if (ent_mask[i]) ent_owner = 2'(i);
    end
    is_owner  = proc_ok && (ent_state == DIR_M) && (ent_mask == req_bit);
    bad       = !in_range || !proc_ok || (req_type_q == 2'b11) ||
                ((req_type_q == REQ_WB) && !is_owner) ||
                ((req_type_q != REQ_WB) && is_owner);

    case (state_q)
      IDLE: begin
        if (ReqValid && req_ready_q) begin
          req_type_d = ReqType;
          req_proc_d = ReqProc;
          req_addr_d = ReqAddress;
          req_data_d = ReqData;
          err_d      = 1'b0;
          state_d    = LOOKUP;
        end
      end
      LOOKUP: begin
        snoop_mask_d = '0;
        owner_d      = ent_owner;
        if (bad) begin
          err_d   = 1'b1;
          data_d  = '0;
          state_d = RESP;
        end else if (req_type_q == REQ_WB) begin
          data_d  = req_data_q;
          state_d = MEM_WR;
        end else if (ent_state == DIR_M) begin
          // Write miss also invalidates the owner while fetching its copy
          if (req_type_q == REQ_WR) snoop_mask_d = ent_mask;
          state_d = FETCH;
        end else if ((req_type_q == REQ_WR) && (ent_state == DIR_S) && (others != '0)) begin
          snoop_mask_d = others;
          state_d      = INVAL;
        end else begin
          state_d = MEM_RD;
        end
      end
      INVAL:  if (SnoopAck) state_d = MEM_RD;
      FETCH: begin
        if (SnoopAck) begin
          data_d  = SnoopData;
          state_d = MEM_WR;
        end
      end
      MEM_WR: if (MemAck) state_d = RESP;
      MEM_RD: begin
        if (MemAck) begin
          data_d  = MemReadData;
          state_d = RESP;
        end
      end
      RESP: begin
        if (!err_q) begin
          case (req_type_q)
            REQ_RD:  begin dir_state_d[idx] = DIR_S; dir_mask_d[idx] = ent_mask | req_bit; end
            REQ_WR:  begin dir_state_d[idx] = DIR_M; dir_mask_d[idx] = req_bit; end
            default: begin dir_state_d[idx] = DIR_I; dir_mask_d[idx] = '0; end
          endcase
        end
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Outputs are registered copies of what the next state presents
    req_ready_d   = (state_d == IDLE);
    mem_read_d    = (state_d == MEM_RD);
    mem_write_d   = (state_d == MEM_WR);
    mem_addr_d    = (mem_read_d || mem_write_d) ? req_addr_d : '0;
    mem_wdata_d   = mem_write_d ? data_d : '0;
    snoop_fetch_d = (state_d == FETCH);
    snoop_inv_d   = ((state_d == INVAL) || snoop_fetch_d) ? snoop_mask_d : '0;
    snoop_owner_d = snoop_fetch_d ? owner_d : '0;
    resp_valid_d  = (state_d == RESP);
    resp_proc_d   = resp_valid_d ? req_proc_d : '0;
    resp_addr_d   = resp_valid_d ? req_addr_d : '0;
    resp_data_d   = resp_valid_d ? data_d : '0;
    resp_error_d  = resp_valid_d && err_d;
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q       <= IDLE;
      req_type_q    <= '0;
      req_proc_q    <= '0;
      req_addr_q    <= '0;
      req_data_q    <= '0;
      data_q        <= '0;
      err_q         <= 1'b0;
      snoop_mask_q  <= '0;
      owner_q       <= '0;
      for (int unsigned i = 0; i < NUM_BLOCKS; i++) begin
        dir_state_q[i] <= DIR_I;
        dir_mask_q[i]  <= '0;
      end
      req_ready_q   <= 1'b0;
      mem_read_q    <= 1'b0;
      mem_write_q   <= 1'b0;
      mem_addr_q    <= '0;
      mem_wdata_q   <= '0;
      snoop_inv_q   <= '0;
      snoop_fetch_q <= 1'b0;
      snoop_owner_q <= '0;
      resp_valid_q  <= 1'b0;
      resp_proc_q   <= '0;
      resp_addr_q   <= '0;
      resp_data_q   <= '0;
      resp_error_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      req_type_q    <= req_type_d;
      req_proc_q    <= req_proc_d;
      req_addr_q    <= req_addr_d;
      req_data_q    <= req_data_d;
      data_q        <= data_d;
      err_q         <= err_d;
      snoop_mask_q  <= snoop_mask_d;
      owner_q       <= owner_d;
      dir_state_q   <= dir_state_d;
      dir_mask_q    <= dir_mask_d;
      req_ready_q   <= req_ready_d;
      mem_read_q    <= mem_read_d;
      mem_write_q   <= mem_write_d;
      mem_addr_q    <= mem_addr_d;
      mem_wdata_q   <= mem_wdata_d;
      snoop_inv_q   <= snoop_inv_d;
      snoop_fetch_q <= snoop_fetch_d;
      snoop_owner_q <= snoop_owner_d;
      resp_valid_q  <= resp_valid_d;
      resp_proc_q   <= resp_proc_d;
      resp_addr_q   <= resp_addr_d;
      resp_data_q   <= resp_data_d;
      resp_error_q  <= resp_error_d;
    end
  end

  assign ReqReady        = req_ready_q;
  assign MemRead         = mem_read_q;
  assign MemWrite        = mem_write_q;
  assign MemAddress      = mem_addr_q;
  assign MemWriteData    = mem_wdata_q;
  assign SnoopInvalidate = snoop_inv_q;
  assign SnoopFetch      = snoop_fetch_q;
  assign SnoopOwner      = snoop_owner_q;
  assign RespValid       = resp_valid_q;
  assign RespProc        = resp_proc_q;
  assign RespAddress     = resp_addr_q;
  assign RespData        = resp_data_q;
  assign RespError       = resp_error_q;

endmodule

// File: tb/tb_directory_controller.sv
// Directed bench for directory_controller with a latency-programmable memory
// and snoop responder.
module tb_directory_controller;

  logic       Clock = 1'b0;
  logic       Reset;
  logic       ReqValid;
  logic [1:0] ReqType, ReqProc;
  logic [3:0] ReqAddress, ReqData;
  logic       ReqReady, MemRead, MemWrite;
  logic [3:0] MemAddress, MemWriteData, MemReadData;
  logic       MemAck;
  logic [2:0] SnoopInvalidate;
  logic       SnoopFetch;
  logic [1:0] SnoopOwner;
  logic [3:0] SnoopData;
  logic       SnoopAck;
  logic       RespValid;
  logic [1:0] RespProc;
  logic [3:0] RespAddress, RespData;
  logic       RespError;

  int checks = 0;
  int failures = 0;

  directory_controller dut (
    .Clock(Clock), .Reset(Reset),
    .ReqValid(ReqValid), .ReqType(ReqType), .ReqProc(ReqProc),
    .ReqAddress(ReqAddress), .ReqData(ReqData), .ReqReady(ReqReady),
    .MemRead(MemRead), .MemWrite(MemWrite), .MemAddress(MemAddress),
    .MemWriteData(MemWriteData), .MemReadData(MemReadData), .MemAck(MemAck),
    .SnoopInvalidate(SnoopInvalidate), .SnoopFetch(SnoopFetch), .SnoopOwner(SnoopOwner),
    .SnoopData(SnoopData), .SnoopAck(SnoopAck),
    .RespValid(RespValid), .RespProc(RespProc), .RespAddress(RespAddress),
    .RespData(RespData), .RespError(RespError)
  );

  always #5 Clock = ~Clock;

  // Memory / snoop responder; memory holds mem[a] = a+1 out of reset
  logic [3:0] mem [16];
  int mem_lat = 2;
  int mem_wait = 0, sn_wait = 0;
  int rd_cnt = 0, wr_cnt = 0, sn_cnt = 0, resp_cnt = 0;
  logic [3:0] last_rd_addr, last_wr_addr, last_wr_data;
  logic [2:0] last_inval;
  logic       last_fetch;
  logic [1:0] last_owner;
  logic [3:0] snoop_val;

  assign MemAck      = (MemRead || MemWrite) && (mem_wait >= mem_lat);
  assign MemReadData = mem[MemAddress];
  assign SnoopAck    = (SnoopFetch || (SnoopInvalidate != 3'b000)) && (sn_wait >= 1);
  assign SnoopData   = snoop_val;

  always @(posedge Clock) begin
    if (Reset) begin
      for (int i = 0; i < 16; i++) mem[i] <= 4'(i + 1);
      mem_wait <= 0;
      sn_wait  <= 0;
    end else begin
      mem_wait <= (!(MemRead || MemWrite) || MemAck) ? 0 : mem_wait + 1;
      sn_wait  <= (!(SnoopFetch || (SnoopInvalidate != 3'b000)) || SnoopAck) ? 0 : sn_wait + 1;
      if (MemAck && MemRead) begin
        rd_cnt <= rd_cnt + 1;
        last_rd_addr <= MemAddress;
      end
      if (MemAck && MemWrite) begin
        wr_cnt <= wr_cnt + 1;
        last_wr_addr <= MemAddress;
        last_wr_data <= MemWriteData;
        mem[MemAddress] <= MemWriteData;
      end
      if (SnoopAck) begin
        sn_cnt <= sn_cnt + 1;
        last_inval <= SnoopInvalidate;
        last_fetch <= SnoopFetch;
        last_owner <= SnoopOwner;
      end
    end
    if (RespValid) resp_cnt <= resp_cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] all_outs();
    return {3'b000, ReqReady, MemRead, MemWrite, MemAddress, MemWriteData, SnoopInvalidate,
            SnoopFetch, SnoopOwner, RespValid, RespProc, RespAddress, RespData, RespError};
  endfunction

  // Issue one request at a negedge and check the response plus memory/snoop activity
  task automatic txn(input string tag, input logic [1:0] t, input logic [1:0] p,
                     input logic [3:0] a, input logic [3:0] d, input logic e_err,
                     input logic [3:0] e_data, input int e_rd, input int e_wr, input int e_sn);
    int n, rd0, wr0, sn0;
    rd0 = rd_cnt; wr0 = wr_cnt; sn0 = sn_cnt;
    n = 0;
    while (!ReqReady && n < 20) begin @(negedge Clock); n++; end
    chk({tag, "_ready"}, 32'(ReqReady), 32'd1);
    ReqValid = 1'b1; ReqType = t; ReqProc = p; ReqAddress = a; ReqData = d;
    @(negedge Clock);
    ReqValid = 1'b0;
    n = 0;
    while (!RespValid && n < 200) begin @(negedge Clock); n++; end
    chk({tag, "_resp_seen"}, 32'(RespValid), 32'd1);
    chk({tag, "_resp_proc"}, 32'(RespProc), 32'(p));
    chk({tag, "_resp_addr"}, 32'(RespAddress), 32'(a));
    chk({tag, "_resp_err"}, 32'(RespError), 32'(e_err));
    chk({tag, "_resp_data"}, 32'(RespData), 32'(e_data));
    @(negedge Clock);
    chk({tag, "_resp_1cyc"}, 32'(RespValid), 32'd0);
    chk({tag, "_mem_rd"}, 32'(rd_cnt - rd0), 32'(e_rd));
    chk({tag, "_mem_wr"}, 32'(wr_cnt - wr0), 32'(e_wr));
    chk({tag, "_snoop"}, 32'(sn_cnt - sn0), 32'(e_sn));
  endtask

  initial begin
    int n, rc0;
    Reset = 1'b1; ReqValid = 1'b0; ReqType = '0; ReqProc = '0; ReqAddress = '0; ReqData = '0;
    snoop_val = 4'h0;
    repeat (3) @(negedge Clock);
    chk("reset_outs", all_outs(), 32'd0);
    Reset = 1'b0;
    @(negedge Clock);
    chk("ready_after_reset", 32'(ReqReady), 32'd1);

    // Minimum-latency read miss P0 @1 with zero-wait memory
    mem_lat = 0;
    ReqValid = 1'b1; ReqType = 2'b00; ReqProc = 2'd0; ReqAddress = 4'd1;
    @(negedge Clock);
    ReqValid = 1'b0;
    chk("lat_ready_drop", 32'(ReqReady), 32'd0);
    chk("lat_memread_early", 32'(MemRead), 32'd0);
    @(negedge Clock);
    chk("lat_memread", 32'(MemRead), 32'd1);
    chk("lat_memaddr", 32'(MemAddress), 32'd1);
    @(negedge Clock);
    chk("lat_resp", 32'(RespValid), 32'd1);
    chk("lat_resp_data", 32'(RespData), 32'd2);
    chk("lat_resp_proc", 32'(RespProc), 32'd0);
    chk("lat_memread_drop", 32'(MemRead), 32'd0);
    @(negedge Clock);
    chk("lat_resp_1cyc", 32'(RespValid), 32'd0);
    mem_lat = 2;

    txn("rd_p1", 2'b00, 2'd1, 4'd1, 4'd0, 1'b0, 4'd2, 1, 0, 0);
    chk("rd_p1_rd_addr", 32'(last_rd_addr), 32'd1);
    txn("wr_p2", 2'b01, 2'd2, 4'd1, 4'd0, 1'b0, 4'd2, 1, 0, 1);
    chk("wr_p2_inval", 32'(last_inval), 32'b011);
    chk("wr_p2_fetch", 32'(last_fetch), 32'd0);
    snoop_val = 4'd5;
    txn("rd_fetch", 2'b00, 2'd0, 4'd1, 4'd0, 1'b0, 4'd5, 0, 1, 1);
    chk("rd_fetch_fetch", 32'(last_fetch), 32'd1);
    chk("rd_fetch_owner", 32'(last_owner), 32'd2);
    chk("rd_fetch_inval", 32'(last_inval), 32'b000);
    chk("rd_fetch_wr_addr", 32'(last_wr_addr), 32'd1);
    chk("rd_fetch_wr_data", 32'(last_wr_data), 32'd5);
    txn("wr_p1_shared", 2'b01, 2'd1, 4'd1, 4'd0, 1'b0, 4'd5, 1, 0, 1);
    chk("wr_p1_inval", 32'(last_inval), 32'b101);
    txn("wr_owner_err", 2'b01, 2'd1, 4'd1, 4'd0, 1'b1, 4'd0, 0, 0, 0);

    txn("wr_p1_b8", 2'b01, 2'd1, 4'd8, 4'd0, 1'b0, 4'd9, 1, 0, 0);
    txn("wb_p1_b8", 2'b10, 2'd1, 4'd8, 4'hA, 1'b0, 4'hA, 0, 1, 0);
    chk("wb_wr_addr", 32'(last_wr_addr), 32'd8);
    chk("wb_wr_data", 32'(last_wr_data), 32'hA);
    txn("wb_again_err", 2'b10, 2'd1, 4'd8, 4'hA, 1'b1, 4'd0, 0, 0, 0);

    txn("addr0_err", 2'b00, 2'd0, 4'd0, 4'd0, 1'b1, 4'd0, 0, 0, 0);
    txn("addr9_err", 2'b00, 2'd0, 4'd9, 4'd0, 1'b1, 4'd0, 0, 0, 0);
    txn("proc3_err", 2'b00, 2'd3, 4'd2, 4'd0, 1'b1, 4'd0, 0, 0, 0);
    txn("type3_err", 2'b11, 2'd0, 4'd2, 4'd0, 1'b1, 4'd0, 0, 0, 0);

    // Reset while MemRead waits on a stalled memory
    mem_lat = 1000;
    rc0 = resp_cnt;
    ReqValid = 1'b1; ReqType = 2'b00; ReqProc = 2'd0; ReqAddress = 4'd2;
    @(negedge Clock);
    ReqValid = 1'b0;
    n = 0;
    while (!MemRead && n < 20) begin @(negedge Clock); n++; end
    chk("rst_mid_memread", 32'(MemRead), 32'd1);
    @(negedge Clock);
    Reset = 1'b1;
    @(negedge Clock);
    chk("rst_mid_outs", all_outs(), 32'd0);
    @(negedge Clock);
    Reset = 1'b0;
    mem_lat = 2;
    @(negedge Clock);
    chk("rst_mid_ready", 32'(ReqReady), 32'd1);
    repeat (5) @(negedge Clock);
    chk("rst_mid_no_resp", 32'(resp_cnt - rc0), 32'd0);
    txn("post_rst_rd", 2'b00, 2'd0, 4'd1, 4'd0, 1'b0, 4'd2, 1, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
